// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - loads program/data images, holds core in reset, then times its run
module boot_sequencer #(
    parameter int IW      = 9,
    parameter int IA      = 10,
    parameter int DW      = 8,
    parameter int DA      = 8,
    parameter int CW      = 16,
    parameter int RST_CYC = 4,
    parameter int MAX_CYC = 5000
) (
    input  logic                           CLK,
    input  logic                           reset_ctrl,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_sel,
    input  logic [((IW > DW) ? IW : DW)-1:0] in_data,
    input  logic                           in_last,
    output logic                           imem_we,
    output logic [IA-1:0]                  imem_addr,
    output logic [IW-1:0]                  imem_wdata,
    output logic                           dmem_we,
    output logic [DA-1:0]                  dmem_addr,
    output logic [DW-1:0]                  dmem_wdata,
    output logic                           cpu_reset,
    input  logic                           cpu_done,
    output logic                           busy,
    output logic                           done,
    output logic                           timeout,
    output logic                           ovf,
    output logic [CW-1:0]                  cycle_count
);

    localparam int HW = $clog2(RST_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_FINISH
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IA-1:0]   iaddr;
    logic [DA-1:0]   daddr;
    logic [HW-1:0]   hold_cnt;
    logic [CW-1:0]   cnt_inc;
    logic            budget_hit;
    logic            xfer;
    logic            sess_clr;
    logic            timeout_set;

    // in_ready is a register mirroring "next state is LOAD", so it is safe to gate the handshake
    assign xfer       = in_valid & in_ready;
    assign cnt_inc    = (cycle_count == '1) ? cycle_count : cycle_count + CW'(1);
    assign budget_hit = (cnt_inc == CW'(MAX_CYC));

    always_ff @(posedge CLK or posedge reset_ctrl) begin
        if (reset_ctrl) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sess_clr    = 1'b0;
        timeout_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    sess_clr  = 1'b1;
                end
            end
            S_LOAD: begin
                if (xfer && in_last) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt == HW'(RST_CYC - 1)) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // a done coinciding with budget exhaustion counts as a normal finish
                if (cpu_done) begin
                    state_nxt = S_FINISH;
                end else if (budget_hit) begin
                    state_nxt   = S_FINISH;
                    timeout_set = 1'b1;
                end
            end
            S_FINISH: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    sess_clr  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset_ctrl) begin
        if (reset_ctrl) begin
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cpu_reset   <= 1'b1;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            iaddr       <= '0;
            daddr       <= '0;
            ovf         <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            hold_cnt    <= '0;
        end else begin
            in_ready  <= (state_nxt == S_LOAD);
            busy      <= (state_nxt == S_LOAD) || (state_nxt == S_HOLD) || (state_nxt == S_RUN);
            done      <= (state_nxt == S_FINISH);
            cpu_reset <= (state_nxt != S_RUN);
            imem_we   <= xfer & ~in_sel;
            dmem_we   <= xfer & in_sel;

            if (xfer && !in_sel) begin
                imem_addr  <= iaddr;
                imem_wdata <= in_data[IW-1:0];
                iaddr      <= iaddr + IA'(1);
                if (iaddr == '1) begin
                    ovf <= 1'b1;
                end
            end
            if (xfer && in_sel) begin
                dmem_addr  <= daddr;
                dmem_wdata <= in_data[DW-1:0];
                daddr      <= daddr + DA'(1);
                if (daddr == '1) begin
                    ovf <= 1'b1;
                end
            end

            hold_cnt <= (state == S_HOLD) ? hold_cnt + HW'(1) : '0;

            if (state == S_RUN) begin
                cycle_count <= cnt_inc;
            end
            if (timeout_set) begin
                timeout <= 1'b1;
            end

            if (sess_clr) begin
                iaddr       <= '0;
                daddr       <= '0;
                ovf         <= 1'b0;
                timeout     <= 1'b0;
                cycle_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_boot_sequencer.sv
// tb/tb_boot_sequencer.sv - directed and randomized sessions against a transaction-level model
module tb_boot_sequencer;

    localparam int IW      = 9;
    localparam int IA      = 3;
    localparam int DW      = 8;
    localparam int DA      = 2;
    localparam int CW      = 16;
    localparam int RST_CYC = 4;
    localparam int MAX_CYC = 20;
    localparam int XW      = 9;

    logic          CLK = 1'b0;
    logic          reset_ctrl = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sel = 1'b0;
    logic [XW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          imem_we;
    logic [IA-1:0] imem_addr;
    logic [IW-1:0] imem_wdata;
    logic          dmem_we;
    logic [DA-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          cpu_reset;
    logic          cpu_done = 1'b0;
    logic          busy;
    logic          done;
    logic          timeout;
    logic          ovf;
    logic [CW-1:0] cycle_count;

    int checks = 0;
    int errors = 0;
    int ia = 0;
    int da = 0;
    bit ovf_m = 0;

    boot_sequencer #(
        .IW(IW), .IA(IA), .DW(DW), .DA(DA), .CW(CW), .RST_CYC(RST_CYC), .MAX_CYC(MAX_CYC)
    ) dut (
        .CLK(CLK), .reset_ctrl(reset_ctrl), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .cpu_reset(cpu_reset), .cpu_done(cpu_done), .busy(busy), .done(done),
        .timeout(timeout), .ovf(ovf), .cycle_count(cycle_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick_nowr();
        tick();
        chk("no_imem_we", imem_we, 0);
        chk("no_dmem_we", dmem_we, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cpu_reset"}, cpu_reset, 1);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_we"}, {imem_we, dmem_we}, 0);
        chk({tag, "_addr"}, {imem_addr, dmem_addr}, 0);
        chk({tag, "_wdata"}, {imem_wdata, dmem_wdata}, 0);
        chk({tag, "_flags"}, {busy, done, timeout, ovf}, 0);
        chk({tag, "_count"}, cycle_count, 0);
    endtask

    task automatic async_reset(input string tag);
        @(posedge CLK);
        #3 reset_ctrl = 1'b1;
        #1;
        chk_reset_vals(tag);
        in_valid = 1'b0;
        in_last  = 1'b0;
        cpu_done = 1'b0;
        start    = 1'b0;
        ia = 0;
        da = 0;
        ovf_m = 0;
        tick();
        #2 reset_ctrl = 1'b0;
        tick();
        chk({tag, "_idle"}, {in_ready, busy, cpu_reset}, 3'b001);
    endtask

    task automatic begin_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        ia = 0;
        da = 0;
        ovf_m = 0;
        chk("sess_in_ready", in_ready, 1);
        chk("sess_busy_done", {busy, done}, 2'b10);
        chk("sess_clear", {timeout, ovf, cycle_count}, 0);
        chk("sess_cpu_reset", cpu_reset, 1);
    endtask

    task automatic xfer(input bit sel, input logic [XW-1:0] data, input bit last, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_sel   = 1'($urandom);
            in_last  = 1'($urandom);
            in_data  = XW'($urandom);
            tick_nowr();
        end
        chk("ld_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        in_last  = last;
        start    = 1'($urandom);
        cpu_done = 1'($urandom);
        tick();
        if (!sel) begin
            chk("imem_we", {imem_we, dmem_we}, 2'b10);
            chk("imem_addr", imem_addr, ia);
            chk("imem_wdata", imem_wdata, data % (1 << IW));
            if (ia == (1 << IA) - 1) ovf_m = 1;
            ia = (ia + 1) % (1 << IA);
        end else begin
            chk("dmem_we", {imem_we, dmem_we}, 2'b01);
            chk("dmem_addr", dmem_addr, da);
            chk("dmem_wdata", dmem_wdata, data % (1 << DW));
            if (da == (1 << DA) - 1) ovf_m = 1;
            da = (da + 1) % (1 << DA);
        end
        chk("ld_ovf", ovf, ovf_m);
        chk("ld_ready_after", in_ready, !last);
        chk("ld_busy", {busy, cpu_reset}, 2'b11);
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        cpu_done = 1'b0;
    endtask

    task automatic hold_phase();
        int n = 0;
        while (cpu_reset === 1'b1 && n < 20) begin
            n++;
            cpu_done = 1'($urandom);
            tick_nowr();
        end
        cpu_done = 1'b0;
        chk("hold_cycles", n, RST_CYC);
        chk("run_entry", {busy, done, cycle_count}, {2'b10, 16'd0});
    endtask

    task automatic run_phase(input int done_at);
        int i = 1;
        int fin = 0;
        int exp_cnt;
        bit exp_to;
        exp_to  = !(done_at >= 1 && done_at <= MAX_CYC);
        exp_cnt = exp_to ? MAX_CYC : done_at;
        while (!fin && i <= MAX_CYC + 5) begin
            cpu_done = (i == done_at);
            start    = 1'($urandom);
            tick();
            if (done === 1'b1) fin = i;
            else chk("run_count", cycle_count, i);
            i++;
        end
        cpu_done = 1'b0;
        start    = 1'b0;
        chk("run_len", fin, exp_cnt);
        chk("fin_count", cycle_count, exp_cnt);
        chk("fin_timeout", timeout, exp_to);
        chk("fin_flags", {cpu_reset, busy, done}, 3'b101);
        chk("fin_ovf", ovf, ovf_m);
        for (int k = 0; k < 2; k++) begin
            cpu_done = 1'($urandom);
            tick_nowr();
            chk("fin_hold", {done, timeout, ovf, cycle_count}, {1'b1, exp_to, ovf_m, 16'(exp_cnt)});
        end
        cpu_done = 1'b0;
    endtask

    initial begin
        #1 reset_ctrl = 1'b1;
        #10;
        chk_reset_vals("por");
        @(posedge CLK);
        #3 reset_ctrl = 1'b0;
        tick_nowr();
        chk("idle_state", {in_ready, busy, done, cpu_reset}, 4'b0001);

        // three imem words then budget timeout
        begin_session();
        xfer(0, 9'h1A5, 0, 0);
        xfer(0, 9'h0FF, 0, 0);
        xfer(0, 9'h100, 1, 0);
        hold_phase();
        run_phase(0);

        // interleaved targets with gaps, done on cycle 10
        begin_session();
        xfer(0, 9'h001, 0, 2);
        xfer(1, 9'h02B, 0, 1);
        xfer(0, 9'h002, 0, 2);
        xfer(1, 9'h03C, 1, 1);
        hold_phase();
        run_phase(10);

        // dmem wrap; done exactly at the budget boundary
        begin_session();
        for (int w = 0; w < 5; w++) xfer(1, XW'($urandom), w == 4, 0);
        hold_phase();
        run_phase(MAX_CYC);

        begin_session();
        xfer(1, 9'h1FF, 1, 0);
        hold_phase();
        run_phase(MAX_CYC - 1);

        for (int s = 0; s < 6; s++) begin
            int n;
            n = $urandom_range(1, 12);
            begin_session();
            for (int w = 0; w < n; w++)
                xfer(1'($urandom), XW'($urandom), w == n - 1, $urandom_range(0, 2));
            hold_phase();
            run_phase($urandom_range(1, MAX_CYC + 4));
        end

        // abort mid-LOAD, then restart from address 0
        begin_session();
        xfer(0, 9'h055, 0, 0);
        xfer(1, 9'h066, 0, 0);
        in_valid = 1'b1;
        in_sel   = 1'b0;
        async_reset("rst_load");
        begin_session();
        xfer(0, 9'h077, 0, 0);
        xfer(1, 9'h088, 1, 0);
        hold_phase();
        run_phase(3);

        // abort mid-RUN, then count restarts from 0
        begin_session();
        xfer(0, 9'h011, 1, 0);
        hold_phase();
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("mid_run_count", cycle_count, c);
        end
        async_reset("rst_run");
        begin_session();
        xfer(1, 9'h0AA, 1, 0);
        hold_phase();
        run_phase(7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog observed timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Front-end controller upstream of the EnDMe processor core.
- Streams a program image and an initial data image from a host/testbench port into instruction memory and data memory.
- Holds the core in reset for a programmable number of cycles, releases it, and counts execution cycles until the core signals done or a cycle budget expires.
- Its `cpu_reset` drives the core's `reset_ctrl` input; its memory write ports feed the instruction ROM image and data memory.

Parameters:
- IW, 9: instruction word width.
- IA, 10: instruction memory address width.
- DW, 8: data word width.
- DA, 8: data memory address width.
- CW, 16: cycle counter width.
- RST_CYC, 4: cycles `cpu_reset` is held high before the run (≥1).
- MAX_CYC, 5000: run budget in cycles (< 2^CW).

Ports:
- CLK  in  1  system clock, rising edge.
- reset_ctrl  in  1  asynchronous, active-high reset of this block.
- start  in  1  begin a load/run session; sampled only in IDLE or FINISH.
- in_valid  in  1  host word valid.
- in_ready  out  1  loader accepts word.
- in_sel  in  1  target of current word: 0 = instruction memory, 1 = data memory.
- in_data  in  max(IW,DW)  host word; low IW or DW bits used.
- in_last  in  1  marks final word of the image.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  IA  instruction memory write address.
- imem_wdata  out  IW  instruction memory write data.
- dmem_we  out  1  data memory write strobe.
- dmem_addr  out  DA  data memory write address.
- dmem_wdata  out  DW  data memory write data.
- cpu_reset  out  1  reset to processor core.
- cpu_done  in  1  core finished (program halt).
- busy  out  1  session in progress (LOAD/HOLD/RUN).
- done  out  1  session complete.
- timeout  out  1  session ended by budget, not `cpu_done`.
- ovf  out  1  sticky: an address counter wrapped during load.
- cycle_count  out  CW  core cycles executed in the run.

Behaviour:

Reset (asynchronous, `reset_ctrl`=1):
- State IDLE.
- `cpu_reset`=1.
- `in_ready`=0.
- `imem_we`=`dmem_we`=0; addresses and wdata = 0.
- `busy`=`done`=`timeout`=`ovf`=0.
- `cycle_count`=0.
- Reset asserted in any state, mid-transfer or mid-run, aborts immediately to these values. Writes in flight are dropped.

States:
- IDLE: `in_ready`=0, `cpu_reset`=1.
  - `start`=1 → LOAD.
  - On entry to LOAD: clear both address counters, `ovf`, `timeout` and `cycle_count`.
- LOAD: `in_ready`=1, `busy`=1, `cpu_reset`=1.
  - A transfer occurs on a cycle with `in_valid`&`in_ready`.
  - One cycle after the transfer, the selected memory's `we`=1 for exactly one cycle, with addr = that target's counter value at transfer and wdata = `in_data` truncated.
  - The other `we` stays 0.
  - The target counter increments by 1 per transfer and wraps to 0 past 2^IA-1 (imem) or 2^DA-1 (dmem). A wrap sets `ovf` sticky.
  - The two counters are independent; any interleaving of `in_sel` is allowed.
  - A transfer with `in_last`=1 → HOLD. `in_ready` drops the following cycle. The final word's write strobe still occurs in HOLD's first cycle.
  - `in_valid` without `in_last` never leaves LOAD.
- HOLD: `cpu_reset`=1, `busy`=1.
  - Remains exactly RST_CYC cycles (internal counter), then → RUN.
- RUN: `cpu_reset`=0, `busy`=1.
  - `cycle_count` increments by 1 every RUN cycle, first RUN cycle included, so the first RUN cycle ends with count 1.
  - `cpu_done`=1 → FINISH. `cycle_count` includes the done cycle.
  - If `cycle_count` reaches MAX_CYC with `cpu_done`=0 → FINISH with `timeout`=1.
  - `cpu_done` in the same cycle the budget is reached: done wins, `timeout`=0.
  - `cycle_count` saturates; it never wraps.
- FINISH: `cpu_reset`=1 (freezes core, memories retain contents), `done`=1, `busy`=0.
  - `cycle_count`, `timeout` and `ovf` are held.
  - `start`=1 → LOAD (new session; `done` clears).
- `start` is ignored in LOAD, HOLD and RUN.
- `cpu_done` is ignored outside RUN.

Timing:
- All outputs are registered. No combinational path from inputs to outputs except none; `in_ready` is state-decoded from registers.

Test Plan:
- Reset then `start`. Stream 3 imem words 0x1A5, 0x0FF, 0x100 (last on third) → `imem_we` pulses at addr 0, 1, 2 with those data one cycle after each handshake. `dmem_we` never asserts. After load, `cpu_reset` stays high exactly 4 cycles, then drops.
- Interleave `in_sel` 0,1,0,1 with data 0x001, 0x2B, 0x002, 0x3C → imem addr 0, 1 and dmem addr 0, 1 written in order. `in_valid` gaps add no writes.
- RUN with `cpu_done` pulsed on the 10th RUN cycle → `done`=1, `cycle_count`=10, `timeout`=0, `cpu_reset` back to 1.
- MAX_CYC=20 and `cpu_done` held 0 → FINISH after 20 RUN cycles, `timeout`=1, `cycle_count`=20. Repeat with `cpu_done`=1 on cycle 20 → `timeout`=0.
- DA=2: load 5 dmem words → addresses 0, 1, 2, 3, 0. `ovf`=1 after the 5th transfer and held through FINISH.
- Assert `reset_ctrl` mid-LOAD and again mid-RUN → all outputs take reset values asynchronously. A new `start` restarts from address 0 and `cycle_count` 0.
